// File: rtl/mat2x2_block_mul_if.sv
// Handshake and operand/result bundle for the 2x2 block multiplier.
// The initiator (matrix multiplier controller) uses the master modport;
// the block multiplier responds through the slave modport.
interface mat2x2_block_mul_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  input_Stable;
    logic                  input_C_Ack;
    logic [DATA_WIDTH-1:0] input_A11;
    logic [DATA_WIDTH-1:0] input_A12;
    logic [DATA_WIDTH-1:0] input_A21;
    logic [DATA_WIDTH-1:0] input_A22;
    logic [DATA_WIDTH-1:0] input_B11;
    logic [DATA_WIDTH-1:0] input_B12;
    logic [DATA_WIDTH-1:0] input_B21;
    logic [DATA_WIDTH-1:0] input_B22;
    logic                  output_AB_Ack;
    logic                  output_Stable;
    logic                  output_Busy;
    logic [DATA_WIDTH-1:0] output_C11;
    logic [DATA_WIDTH-1:0] output_C12;
    logic [DATA_WIDTH-1:0] output_C21;
    logic [DATA_WIDTH-1:0] output_C22;

    modport master (
        output input_Stable, input_C_Ack,
        output input_A11, input_A12, input_A21, input_A22,
        output input_B11, input_B12, input_B21, input_B22,
        input  output_AB_Ack, output_Stable, output_Busy,
        input  output_C11, output_C12, output_C21, output_C22
    );

    modport slave (
        input  input_Stable, input_C_Ack,
        input  input_A11, input_A12, input_A21, input_A22,
        input  input_B11, input_B12, input_B21, input_B22,
        output output_AB_Ack, output_Stable, output_Busy,
        output output_C11, output_C12, output_C21, output_C22
    );
endinterface

// File: rtl/mat2x2_block_mul.sv
// 2x2 block multiplier, responder side of the block-multiply handshake.
// Captures A and B, forms C = A*B over eight multiply-accumulate steps
// sharing one multiplier, then holds C until the initiator acknowledges.
// Optional feature macro: MAT2X2_SAT_EN -- when defined, each result
// element saturates to the signed DATA_WIDTH range instead of wrapping.
module mat2x2_block_mul #(
    parameter int DATA_WIDTH = 32
) (
    input logic               input_Clk,
    input logic               input_Reset,
    mat2x2_block_mul_if.slave bus
);
    localparam int W = DATA_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

`ifdef MAT2X2_SAT_EN
    localparam logic signed [2*W:0] SAT_MAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W:0] SAT_MIN = {{(W+2){1'b1}}, {(W-1){1'b0}}};
`endif

    logic [1:0]              state;
    logic [2:0]              step;
    logic signed [2*W:0]     acc;
    logic signed [W-1:0]     a11, a12, a21, a22;
    logic signed [W-1:0]     b11, b12, b21, b22;
    logic signed [W-1:0]     mul_a, mul_b;
    logic signed [2*W-1:0]   mul_a_ext, mul_b_ext;
    logic signed [2*W-1:0]   prod;
    logic signed [2*W:0]     sum;

    // Reduce the full-precision sum to one result element.
    function automatic logic [W-1:0] final_value(input logic signed [2*W:0] s);
`ifdef MAT2X2_SAT_EN
        if (s > SAT_MAX) begin
            return SAT_MAX[W-1:0];
        end
        if (s < SAT_MIN) begin
            return SAT_MIN[W-1:0];
        end
`endif
        return s[W-1:0];
    endfunction

    // Pick multiplier operands: step[2] selects the A row, step[1] the B
    // column, step[0] the first or second term of the dot product.
    always_comb begin
        mul_a = a11;
        mul_b = b11;
        if (step[0] == 1'b0) begin
            mul_a = step[2] ? a21 : a11;
            mul_b = step[1] ? b12 : b11;
        end else begin
            mul_a = step[2] ? a22 : a12;
            mul_b = step[1] ? b22 : b21;
        end
    end

    assign mul_a_ext = {{W{mul_a[W-1]}}, mul_a};
    assign mul_b_ext = {{W{mul_b[W-1]}}, mul_b};
    assign prod      = mul_a_ext * mul_b_ext;
    assign sum       = acc + {prod[2*W-1], prod};

    // Handshake state machine plus the shared multiply-accumulate datapath.
    always_ff @(posedge input_Clk) begin
        if (!input_Reset) begin
            state             <= S_IDLE;
            step              <= '0;
            acc               <= '0;
            a11               <= '0;
            a12               <= '0;
            a21               <= '0;
            a22               <= '0;
            b11               <= '0;
            b12               <= '0;
            b21               <= '0;
            b22               <= '0;
            bus.output_AB_Ack <= 1'b0;
            bus.output_Stable <= 1'b0;
            bus.output_Busy   <= 1'b0;
            bus.output_C11    <= '0;
            bus.output_C12    <= '0;
            bus.output_C21    <= '0;
            bus.output_C22    <= '0;
        end else begin
            bus.output_AB_Ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.input_Stable) begin
                        a11               <= bus.input_A11;
                        a12               <= bus.input_A12;
                        a21               <= bus.input_A21;
                        a22               <= bus.input_A22;
                        b11               <= bus.input_B11;
                        b12               <= bus.input_B12;
                        b21               <= bus.input_B21;
                        b22               <= bus.input_B22;
                        step              <= '0;
                        bus.output_AB_Ack <= 1'b1;
                        bus.output_Busy   <= 1'b1;
                        state             <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (step[0] == 1'b0) begin
                        acc <= {prod[2*W-1], prod};
                    end else begin
                        case (step[2:1])
                            2'd0:    bus.output_C11 <= final_value(sum);
                            2'd1:    bus.output_C12 <= final_value(sum);
                            2'd2:    bus.output_C21 <= final_value(sum);
                            default: bus.output_C22 <= final_value(sum);
                        endcase
                    end
                    step <= step + 3'd1;
                    if (step == 3'd7) begin
                        bus.output_Stable <= 1'b1;
                        state             <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.input_C_Ack) begin
                        bus.output_Stable <= 1'b0;
                        bus.output_Busy   <= 1'b0;
                        state             <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mat2x2_block_mul.sv
// Self-checking bench for mat2x2_block_mul with a plain-arithmetic
// reference model. Honours MAT2X2_SAT_EN for the expected results.
module tb_mat2x2_block_mul;
    typedef logic [3:0][31:0] blk_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mat2x2_block_mul_if #(.DATA_WIDTH(32)) bus ();

    mat2x2_block_mul #(.DATA_WIDTH(32)) dut (
        .input_Clk   (clk),
        .input_Reset (rst_n),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reduce an exact sum to a 32-bit result element.
    function automatic logic [31:0] fin(input logic signed [64:0] s);
`ifdef MAT2X2_SAT_EN
        if (s > 65'sd2147483647) return 32'h7FFFFFFF;
        if (s < -65'sd2147483648) return 32'h80000000;
`endif
        return s[31:0];
    endfunction

    // Reference: index 0=11, 1=12, 2=21, 3=22; ordinary matrix product.
    function automatic blk_t model(input blk_t a, input blk_t b);
        logic signed [64:0] ea [4];
        logic signed [64:0] eb [4];
        blk_t c;
        for (int i = 0; i < 4; i++) begin
            ea[i] = {{33{a[i][31]}}, a[i]};
            eb[i] = {{33{b[i][31]}}, b[i]};
        end
        for (int r = 0; r < 2; r++) begin
            for (int col = 0; col < 2; col++) begin
                c[r*2+col] = fin(ea[r*2] * eb[col] + ea[r*2+1] * eb[2+col]);
            end
        end
        return c;
    endfunction

    function automatic blk_t read_c();
        return {bus.output_C22, bus.output_C21, bus.output_C12, bus.output_C11};
    endfunction

    task automatic set_ops(input blk_t a, input blk_t b);
        bus.input_A11 = a[0]; bus.input_A12 = a[1];
        bus.input_A21 = a[2]; bus.input_A22 = a[3];
        bus.input_B11 = b[0]; bus.input_B12 = b[1];
        bus.input_B21 = b[2]; bus.input_B22 = b[3];
    endtask

    // Issue one request from a falling edge and collect timing and result;
    // leaves the block in its done state without acknowledging.
    task automatic run_block(input blk_t a, input blk_t b, output int ack_lat,
                             output int stb_lat, output int busy_low,
                             output int extra_acks, output blk_t c);
        @(negedge clk);
        set_ops(a, b);
        bus.input_Stable = 1'b1;
        ack_lat = 0;
        busy_low = 0;
        extra_acks = 0;
        do begin
            @(negedge clk);
            ack_lat++;
        end while (!bus.output_AB_Ack && ack_lat < 20);
        bus.input_Stable = 1'b0;
        stb_lat = 0;
        while (!bus.output_Stable && stb_lat < 40) begin
            if (!bus.output_Busy) busy_low++;
            @(negedge clk);
            stb_lat++;
            if (bus.output_AB_Ack) extra_acks++;
        end
        c = read_c();
    endtask

    task automatic ack_block();
        bus.input_C_Ack = 1'b1;
        @(negedge clk);
        bus.input_C_Ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.input_Stable = 1'b0;
        bus.input_C_Ack = 1'b0;
        set_ops('0, '0);
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.output_AB_Ack, bus.output_Stable, bus.output_Busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000",
                     {bus.output_AB_Ack, bus.output_Stable, bus.output_Busy});
        end
        checks++;
        if (read_c() !== '0) begin
            errors++;
            $display("FAIL reset_c got %h want 0", read_c());
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        blk_t a, b, c, exp;
        int al, sl, bl, ea;
        a = {32'd4, 32'd3, 32'd2, 32'd1};
        b = {32'd8, 32'd7, 32'd6, 32'd5};
        exp = {32'd50, 32'd43, 32'd22, 32'd19};
        run_block(a, b, al, sl, bl, ea, c);
        checks++;
        if (al !== 1) begin errors++; $display("FAIL basic_ack_lat got %0d want 1", al); end
        checks++;
        if (sl !== 8) begin errors++; $display("FAIL basic_stable_lat got %0d want 8", sl); end
        checks++;
        if (bl !== 0 || !bus.output_Busy) begin
            errors++; $display("FAIL basic_busy got %0d low cycles want 0", bl);
        end
        checks++;
        if (c !== exp) begin errors++; $display("FAIL basic_c got %h want %h", c, exp); end
        ack_block();
        checks++;
        if (bus.output_Stable !== 1'b0 || bus.output_Busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_ack got stable=%b busy=%b want 0 0",
                     bus.output_Stable, bus.output_Busy);
        end
        checks++;
        if (read_c() !== exp) begin
            errors++; $display("FAIL basic_c_kept got %h want %h", read_c(), exp);
        end
    endtask

    task automatic test_random();
        blk_t a, b, c, exp;
        int al, sl, bl, ea;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (n < 4) begin
                    a[i] = 32'($signed($urandom_range(0, 2000)) - 1000);
                    b[i] = 32'($signed($urandom_range(0, 2000)) - 1000);
                end else begin
                    a[i] = $urandom;
                    b[i] = $urandom;
                end
            end
            exp = model(a, b);
            run_block(a, b, al, sl, bl, ea, c);
            checks++;
            if (c !== exp || sl !== 8 || ea !== 0) begin
                errors++;
                $display("FAIL random_%0d got c=%h lat=%0d acks=%0d want c=%h lat=8 acks=0",
                         n, c, sl, ea, exp);
            end
            ack_block();
        end
    endtask

    task automatic test_boundary();
        blk_t a, b, c, exp;
        int al, sl, bl, ea;
        logic [31:0] want;
        a = {32'd0, 32'd0, 32'd0, 32'hFFFFFFFE};
        b = {32'd0, 32'd0, 32'd0, 32'd3};
        run_block(a, b, al, sl, bl, ea, c);
        checks++;
        if (c !== {96'd0, 32'hFFFFFFFA}) begin
            errors++; $display("FAIL bound_neg got %h want %h", c, {96'd0, 32'hFFFFFFFA});
        end
        ack_block();
        a = {32'd0, 32'd0, 32'd0, 32'h00010000};
        b = {32'd0, 32'd0, 32'd0, 32'h00010000};
`ifdef MAT2X2_SAT_EN
        want = 32'h7FFFFFFF;
`else
        want = 32'h00000000;
`endif
        run_block(a, b, al, sl, bl, ea, c);
        checks++;
        if (c[0] !== want) begin errors++; $display("FAIL bound_pos_ovf got %h want %h", c[0], want); end
        ack_block();
        b = {32'd0, 32'd0, 32'd0, 32'hFFFF0000};
`ifdef MAT2X2_SAT_EN
        want = 32'h80000000;
`else
        want = 32'h00000000;
`endif
        run_block(a, b, al, sl, bl, ea, c);
        checks++;
        if (c[0] !== want) begin errors++; $display("FAIL bound_neg_ovf got %h want %h", c[0], want); end
        ack_block();
        a = {32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h80000000};
        b = {32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h80000000};
        exp = model(a, b);
        run_block(a, b, al, sl, bl, ea, c);
        checks++;
        if (c !== exp) begin errors++; $display("FAIL bound_extreme got %h want %h", c, exp); end
        ack_block();
    endtask

    task automatic test_back_to_back();
        blk_t a, b, c, exp, a2, b2, exp2;
        int al, sl, bl, ea, cnt;
        a = {32'd1, 32'd2, 32'd3, 32'd4};
        b = {32'd5, 32'd6, 32'd7, 32'd8};
        exp = model(a, b);
        run_block(a, b, al, sl, bl, ea, c);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.output_Stable || read_c() !== exp) begin
                cnt = i;
                break;
            end
        end
        checks++;
        if (bus.output_Stable !== 1'b1 || read_c() !== exp) begin
            errors++;
            $display("FAIL hold_c got stable=%b c=%h want 1 %h", bus.output_Stable, read_c(), exp);
        end
        a2 = {32'd9, 32'hFFFFFFFD, 32'd11, 32'd12};
        b2 = {32'd2, 32'd0, 32'hFFFFFFF0, 32'd7};
        exp2 = model(a2, b2);
        set_ops(a2, b2);
        bus.input_C_Ack = 1'b1;
        bus.input_Stable = 1'b1;
        @(negedge clk);
        bus.input_C_Ack = 1'b0;
        checks++;
        if (bus.output_Stable !== 1'b0 || bus.output_AB_Ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_edge got stable=%b abAck=%b want 0 0",
                     bus.output_Stable, bus.output_AB_Ack);
        end
        @(negedge clk);
        checks++;
        if (bus.output_AB_Ack !== 1'b1) begin
            errors++; $display("FAIL next_capture got abAck=%b want 1", bus.output_AB_Ack);
        end
        bus.input_Stable = 1'b0;
        cnt = 0;
        while (!bus.output_Stable && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt !== 8 || read_c() !== exp2) begin
            errors++;
            $display("FAIL b2b_result got lat=%0d c=%h want 8 %h", cnt, read_c(), exp2);
        end
        ack_block();
    endtask

    task automatic test_ignore();
        blk_t a, b, exp;
        int cnt, acks;
        a = {32'd7, 32'hFFFFFFF9, 32'd5, 32'd3};
        b = {32'd2, 32'd4, 32'hFFFFFFFF, 32'd6};
        exp = model(a, b);
        @(negedge clk);
        set_ops(a, b);
        bus.input_Stable = 1'b1;
        @(negedge clk);
        bus.input_C_Ack = 1'b1;
        cnt = 0;
        acks = 0;
        while (!bus.output_Stable && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (bus.output_AB_Ack) acks++;
        end
        bus.input_C_Ack = 1'b0;
        set_ops('1, '1);
        checks++;
        if (cnt !== 8 || acks !== 0 || read_c() !== exp) begin
            errors++;
            $display("FAIL ignore_calc got lat=%0d acks=%0d c=%h want 8 0 %h", cnt, acks, read_c(), exp);
        end
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.output_AB_Ack || !bus.output_Stable) acks++;
        end
        checks++;
        if (acks !== 0 || read_c() !== exp) begin
            errors++;
            $display("FAIL ignore_done got bad=%0d c=%h want 0 %h", acks, read_c(), exp);
        end
        bus.input_Stable = 1'b0;
        ack_block();
    endtask

    task automatic test_reset_mid();
        blk_t a, b, c, exp;
        int al, sl, bl, ea, bad;
        a = {32'd1, 32'd1, 32'd1, 32'd1};
        b = {32'd2, 32'd2, 32'd2, 32'd2};
        @(negedge clk);
        set_ops(a, b);
        bus.input_Stable = 1'b1;
        @(negedge clk);
        bus.input_Stable = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({bus.output_AB_Ack, bus.output_Stable, bus.output_Busy} !== 3'b000 || read_c() !== '0) begin
            errors++;
            $display("FAIL mid_reset got flags=%b c=%h want 000 0",
                     {bus.output_AB_Ack, bus.output_Stable, bus.output_Busy}, read_c());
        end
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.output_AB_Ack || bus.output_Stable || bus.output_Busy) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL mid_reset_quiet got %0d want 0", bad); end
        a = {32'd3, 32'hFFFFFFFB, 32'd8, 32'd2};
        b = {32'd1, 32'd9, 32'd4, 32'hFFFFFFFA};
        exp = model(a, b);
        run_block(a, b, al, sl, bl, ea, c);
        checks++;
        if (al !== 1 || sl !== 8 || c !== exp) begin
            errors++;
            $display("FAIL after_reset got ack=%0d lat=%0d c=%h want 1 8 %h", al, sl, c, exp);
        end
        ack_block();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_random();
        test_boundary();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mat2x2_block_mul.md
# mat2x2_block_mul

Responder side of the 2x2 block-multiply handshake issued by the matrix multiplier controller. It accepts two 2x2 operand blocks A and B, computes C = A·B over eight sequential multiply-accumulate steps with one multiplier, and presents C until the initiator acknowledges it. Instances sit between the controller's block fetch logic and its result adder, one instance per multiplier slot.

## Interface
- DATA_WIDTH, 32, width of every operand and result element; two's complement signed.
- input_Clk  input  1  single clock; all logic on rising edge.
- input_Reset  input  1  reset, synchronous, active-low.
- input_Stable  input  1  initiator request: A/B operands valid (level).
- input_C_Ack  input  1  initiator has consumed C.
- input_A11, input_A12, input_A21, input_A22  input  DATA_WIDTH each  block A.
- input_B11, input_B12, input_B21, input_B22  input  DATA_WIDTH each  block B.
- output_AB_Ack  output  1  one-cycle pulse: operands captured.
- output_Stable  output  1  C valid; held until acknowledged.
- output_Busy  output  1  high from capture until C acknowledged.
- output_C11, output_C12, output_C21, output_C22  output  DATA_WIDTH each  result block.

## Operation
- States: S_IDLE, S_CALC, S_DONE. Reset state S_IDLE.
- S_IDLE: input_Stable=1 sampled → register all eight operands, step counter←0, output_AB_Ack←1, output_Busy←1, → S_CALC.
- S_CALC: one step per cycle, steps 0..7. Step 2k: acc←product of first term of element k. Step 2k+1: element k←final(acc + second-term product).
- Element order and terms: C11=A11·B11+A12·B21; C12=A11·B12+A12·B22; C21=A21·B11+A22·B21; C22=A21·B12+A22·B22.
- Products full precision, 2·DATA_WIDTH signed; acc and sum 2·DATA_WIDTH+1 signed.
- final(): low DATA_WIDTH bits of the sum (wrap), unless MAT2X2_SAT_EN.
- After step 7 → S_DONE, output_Stable←1.
- S_DONE: input_C_Ack=1 sampled → output_Stable←0, output_Busy←0, → S_IDLE. C outputs keep their values.
- input_Stable outside S_IDLE ignored; no second ack. input_C_Ack outside S_DONE ignored.
- Initiator must drop input_Stable after seeing output_AB_Ack; held high into S_IDLE it starts a new operation.
- output_C* change only at odd CALC steps; valid only while output_Stable=1.

## Timing
- Reset (input_Reset=0 at an edge): state S_IDLE, output_AB_Ack=0, output_Stable=0, output_Busy=0, output_C*=0, acc and counter 0. Reset mid-operation discards the operation; no ack or result follows.
- Capture edge N: output_AB_Ack high for exactly the cycle after edge N.
- Steps at edges N+1..N+8; output_C11 written at N+2, C12 at N+4, C21 at N+6, C22 at N+8; output_Stable high after edge N+8.
- input_C_Ack sampled at edge M in S_DONE: output_Stable low after M; earliest next capture at edge M+1.
- Minimum period per block: 10 cycles (capture, 8 steps, ack).
- input_C_Ack and input_Stable both high in S_DONE: ack processed, request ignored that edge, captured at M+1 if still high.

## Configuration
- MAT2X2_SAT_EN defined: final() saturates the 2·DATA_WIDTH+1 sum to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- Not defined: final() truncates to low DATA_WIDTH bits (modular wrap). No other behaviour differs; latency identical.

## Test plan
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], pulse input_Stable → AB_Ack one cycle after capture; output_Stable 8 cycles later; C=[[19,22],[43,50]]; output_Busy high throughout until ack.
- A11=−2, B11=3, all others 0 → C11=−6 (0xFFFFFFFA at DATA_WIDTH=32), other C=0.
- A11=B11=0x00010000, others 0 → C11=0 without MAT2X2_SAT_EN; 0x7FFFFFFF with it. A11=0x00010000, B11=0xFFFF0000 → 0 without; 0x80000000 with.
- Hold input_C_Ack low 20 cycles after output_Stable → C and output_Stable held; then pulse ack → Stable low next cycle; second request issued same cycle as ack captured one edge later, result correct.
- Assert input_Stable during S_CALC and S_DONE → no extra AB_Ack, C unaffected; input_C_Ack during S_CALC → ignored, Stable still rises at N+8.
- input_Reset=0 at step 4 → next cycle all outputs 0, state S_IDLE; new request afterwards gives correct C with normal latency.
